mult_arbiter: RTL

Round-robin arbiter that shares one `Multiplicator` instance among `NUM_REQ` requesters. It captures the winning requester's operands and drives the multiplier's valid/acknowledge handshake. It returns the 64-bit product to that requester over a per-requester done/ack handshake. It sits between client blocks and the multiplier datapath, and owns that datapath's `iValid_Data` and `iAcknoledged` inputs.

---
 rtl/mult_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
//
// Shares a single multiplier among NUM_REQ requesters. A round-robin search
// picks one pending requester, its operands are captured and offered to the
// multiplier, and the 2*DATA_W-bit product is handed back to that requester.
//
// Ports
//   Clock, Reset        : rising-edge clock, synchronous active-low reset
//   iReq                : per-requester request, held until its grant pulse
//   iData_A/B_Req       : packed operands, requester i at [i*DATA_W +: DATA_W]
//   oGrant              : one-hot, one-cycle pulse: operands captured
//   oDone_Req           : one-hot, oResult is valid for the flagged requester
//   iAck_Req            : requester has consumed the result
//   oResult             : registered product, shared by all requesters
//   oBusy               : high whenever the FSM is not in IDLE
//   oMult_A/B           : latched operands to the multiplier
//   oMult_Valid         : multiplier iValid_Data
//   oMult_Ack           : multiplier iAcknoledged
//   iMult_Idle/Done     : multiplier oIdle / oDone
//   iMult_Result        : multiplier oResult
//   oDbg_State          : current FSM state (IDLE=0 .. DELIVER=4)
//
// Handshakes (all outputs are registered):
//   Multiplier side: oMult_Valid rises with the grant and holds until the
//   multiplier reports iMult_Idle low (accepted). After iMult_Done is seen
//   high the product is registered and oMult_Ack is raised; it holds until
//   iMult_Done is seen low.
//   Requester side: oDone_Req[g] holds until iAck_Req[g] is seen high; ack
//   bits of other requesters, or acks outside delivery, have no effect.
// ---------------------------------------------------------------------------
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ*DATA_W-1:0] iData_A_Req,
    input  logic [NUM_REQ*DATA_W-1:0] iData_B_Req,
    output logic [NUM_REQ-1:0]        oGrant,
    output logic [NUM_REQ-1:0]        oDone_Req,
    input  logic [NUM_REQ-1:0]        iAck_Req,
    output logic [2*DATA_W-1:0]       oResult,
    output logic                      oBusy,
    output logic [DATA_W-1:0]         oMult_A,
    output logic [DATA_W-1:0]         oMult_B,
    output logic                      oMult_Valid,
    output logic                      oMult_Ack,
    input  logic                      iMult_Idle,
    input  logic                      iMult_Done,
    input  logic [2*DATA_W-1:0]       iMult_Result,
    output logic [2:0]                oDbg_State
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_MACK    = 3'd3,
        S_DELIVER = 3'd4
    } state_t;

    state_t                state_q,  state_d;
    logic [IDX_W-1:0]      ptr_q,    ptr_d;
    logic [IDX_W-1:0]      gidx_q,   gidx_d;
    logic [NUM_REQ-1:0]    grant_q,  grant_d;
    logic [NUM_REQ-1:0]    done_q,   done_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]     a_q,      a_d;
    logic [DATA_W-1:0]     b_q,      b_d;
    logic                  valid_q,  valid_d;
    logic                  ack_q,    ack_d;
    logic                  busy_q,   busy_d;

    // Round-robin search: first requester at or after ptr_q, wrapping.
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W:0]        cand_sum;
    logic [IDX_W-1:0]      cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!win_found && iReq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = '0;          // grant is a single-cycle pulse
        done_d   = done_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        ack_d    = ack_q;

        case (state_q)
            S_IDLE: begin
                if (iMult_Idle && win_found) begin
                    gidx_d           = win_idx;
                    grant_d[win_idx] = 1'b1;
                    a_d              = iData_A_Req[win_idx*DATA_W +: DATA_W];
                    b_d              = iData_B_Req[win_idx*DATA_W +: DATA_W];
                    valid_d          = 1'b1;
                    if (win_idx == IDX_W'(NUM_REQ-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + IDX_W'(1);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Multiplier leaving idle is its acceptance of the operands.
                if (!iMult_Idle) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iMult_Done) begin
                    result_d = iMult_Result;
                    ack_d    = 1'b1;
                    state_d  = S_MACK;
                end
            end
            S_MACK: begin
                if (!iMult_Done) begin
                    ack_d          = 1'b0;
                    done_d         = '0;
                    done_d[gidx_q] = 1'b1;
                    state_d        = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (iAck_Req[gidx_q]) begin
                    done_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign oGrant      = grant_q;
    assign oDone_Req   = done_q;
    assign oResult     = result_q;
    assign oBusy       = busy_q;
    assign oMult_A     = a_q;
    assign oMult_B     = b_q;
    assign oMult_Valid = valid_q;
    assign oMult_Ack   = ack_q;
    assign oDbg_State  = state_q;

endmodule
